// File: rtl/shift_reg_univ_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// the per-bit next-state select, and the mode-to-select mapping.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_RSVD  = 3'b111;

  // Per-bit source select. SEL_LEFT takes the lower neighbour (left
  // shift/rotate), SEL_RIGHT takes the upper neighbour (right shift/rotate).
  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_PAR   = 3'd1,
    SEL_LEFT  = 3'd2,
    SEL_RIGHT = 3'd3,
    SEL_RST   = 3'd4
  } cell_sel_e;

  // Shift and rotate share a select; they differ only in what the top
  // level feeds into the end bits.
  function automatic cell_sel_e mode_to_sel(input logic [2:0] mode);
    cell_sel_e sel;
    case (mode)
      MODE_LOAD:             sel = SEL_PAR;
      MODE_SHL, MODE_ROTL:   sel = SEL_LEFT;
      MODE_SHR, MODE_ROTR:   sel = SEL_RIGHT;
      MODE_CLEAR:            sel = SEL_RST;
      default:               sel = SEL_HOLD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle for shift_reg_univ. The master drives controls and
// data; the slave (the register) returns its contents and status.
interface shift_reg_univ_if #(parameter int WIDTH = 8);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             zero;

  modport master (
    output en, mode, d, sin_r, sin_l,
    input  q, sout_l, sout_r, zero
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l,
    output q, sout_l, sout_r, zero
  );

endinterface

// File: rtl/shift_reg_univ_cell.sv
// One bit slice of the universal shift register: source mux followed by a
// synchronous-reset, enabled D flip-flop.
module shift_cell
  import shift_reg_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rst_bit,
  input  logic      en,
  input  cell_sel_e sel,
  input  logic      par,
  input  logic      left,
  input  logic      right,
  output logic      q
);

  logic d_next;

  // Select the next value of this bit from the chosen source.
  always_comb begin
    d_next = q;
    case (sel)
      SEL_PAR:   d_next = par;
      SEL_LEFT:  d_next = left;
      SEL_RIGHT: d_next = right;
      SEL_RST:   d_next = rst_bit;
      default:   d_next = q;
    endcase
  end

  // Storage bit: reset dominates, then enable gates the update.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_bit;
    end else if (en) begin
      q <= d_next;
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register built from WIDTH shift_cell slices.
// Hold, load, shift left/right, rotate left/right and clear.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  shift_reg_univ_if.slave    bus
);

  logic [WIDTH-1:0] q_int;
  cell_sel_e        sel;
  logic             lsb_in;
  logic             msb_in;

  // Mode decode and end-bit feeds: rotates wrap the opposite end, shifts
  // take the serial inputs. With WIDTH=1 a rotate feeds the bit to itself.
  always_comb begin
    sel    = mode_to_sel(bus.mode);
    lsb_in = (bus.mode == MODE_ROTL) ? q_int[WIDTH-1] : bus.sin_r;
    msb_in = (bus.mode == MODE_ROTR) ? q_int[0]       : bus.sin_l;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic left_in;
    logic right_in;

    if (i == 0) begin : g_lsb
      assign left_in = lsb_in;
    end else begin : g_lmid
      assign left_in = q_int[i-1];
    end

    if (i == WIDTH-1) begin : g_msb
      assign right_in = msb_in;
    end else begin : g_rmid
      assign right_in = q_int[i+1];
    end

    shift_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_bit (RST_VAL[i]),
      .en      (bus.en),
      .sel     (sel),
      .par     (bus.d[i]),
      .left    (left_in),
      .right   (right_in),
      .q       (q_int[i])
    );
  end

  assign bus.q      = q_int;
  assign bus.sout_l = q_int[WIDTH-1];
  assign bus.sout_r = q_int[0];
  assign bus.zero   = (q_int == '0);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: three instances (8/0, 1/1,
// 16/FFFF) driven in lockstep, compared against an arithmetic model.
module tb_shift_reg_univ;

  logic clk;
  logic rst;

  shift_reg_univ_if #(.WIDTH(8))  ifc8  ();
  shift_reg_univ_if #(.WIDTH(1))  ifc1  ();
  shift_reg_univ_if #(.WIDTH(16)) ifc16 ();

  shift_reg_univ #(.WIDTH(8),  .RST_VAL(8'h00))     dut8  (.clk(clk), .rst(rst), .bus(ifc8));
  shift_reg_univ #(.WIDTH(1),  .RST_VAL(1'b1))      dut1  (.clk(clk), .rst(rst), .bus(ifc1));
  shift_reg_univ #(.WIDTH(16), .RST_VAL(16'hFFFF))  dut16 (.clk(clk), .rst(rst), .bus(ifc16));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int          w_of  [3] = '{8, 1, 16};
  logic [31:0] rv_of [3] = '{32'h0, 32'h1, 32'hFFFF};
  logic [31:0] m     [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Next register value from the mode table, with plain shifts and masks.
  function automatic logic [31:0] model_next(input int w, input logic [31:0] rv,
                                             input logic [31:0] q, input logic [2:0] md,
                                             input logic [31:0] dv, input logic sr,
                                             input logic sl);
    logic [31:0] mask;
    logic [31:0] r;
    logic [31:0] sr32;
    logic [31:0] sl32;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    sr32 = {31'b0, sr};
    sl32 = {31'b0, sl};
    case (md)
      3'd1:    r = dv;
      3'd2:    r = (q << 1) | sr32;
      3'd3:    r = (q >> 1) | (sl32 << (w - 1));
      3'd4:    r = (q << 1) | (q >> (w - 1));
      3'd5:    r = (q >> 1) | (q << (w - 1));
      3'd6:    r = rv;
      default: r = q;
    endcase
    return r & mask;
  endfunction

  task automatic observe(input int k, output logic [31:0] q, output logic sl,
                         output logic sr, output logic z);
    case (k)
      0:       begin q = {24'b0, ifc8.q};  sl = ifc8.sout_l;  sr = ifc8.sout_r;  z = ifc8.zero;  end
      1:       begin q = {31'b0, ifc1.q};  sl = ifc1.sout_l;  sr = ifc1.sout_r;  z = ifc1.zero;  end
      default: begin q = {16'b0, ifc16.q}; sl = ifc16.sout_l; sr = ifc16.sout_r; z = ifc16.zero; end
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [31:0] q;
    logic        sl, sr, z;
    for (int k = 0; k < 3; k++) begin
      observe(k, q, sl, sr, z);
      check($sformatf("%s.w%0d.q", tag, w_of[k]), q, m[k]);
      check($sformatf("%s.w%0d.sout_l", tag, w_of[k]), {31'b0, sl}, (m[k] >> (w_of[k] - 1)) & 32'h1);
      check($sformatf("%s.w%0d.sout_r", tag, w_of[k]), {31'b0, sr}, m[k] & 32'h1);
      check($sformatf("%s.w%0d.zero", tag, w_of[k]), {31'b0, z}, {31'b0, m[k] == 32'h0});
    end
  endtask

  // Apply one cycle of stimulus to all instances, advance the model, check.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] md,
                      input logic [31:0] dv, input logic sr, input logic sl);
    logic [31:0] nxt [3];
    rst = r;
    ifc8.en  = e;  ifc8.mode  = md; ifc8.d  = dv[7:0];  ifc8.sin_r  = sr; ifc8.sin_l  = sl;
    ifc1.en  = e;  ifc1.mode  = md; ifc1.d  = dv[0];    ifc1.sin_r  = sr; ifc1.sin_l  = sl;
    ifc16.en = e;  ifc16.mode = md; ifc16.d = dv[15:0]; ifc16.sin_r = sr; ifc16.sin_l = sl;
    for (int k = 0; k < 3; k++) begin
      if (r)      nxt[k] = rv_of[k];
      else if (e) nxt[k] = model_next(w_of[k], rv_of[k], m[k], md, dv, sr, sl);
      else        nxt[k] = m[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) m[k] = nxt[k];
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0;
    ifc8.en = 1'b0;  ifc8.mode = 3'd0;  ifc8.d = '0;  ifc8.sin_r = 1'b0;  ifc8.sin_l = 1'b0;
    ifc1.en = 1'b0;  ifc1.mode = 3'd0;  ifc1.d = '0;  ifc1.sin_r = 1'b0;  ifc1.sin_l = 1'b0;
    ifc16.en = 1'b0; ifc16.mode = 3'd0; ifc16.d = '0; ifc16.sin_r = 1'b0; ifc16.sin_l = 1'b0;
    @(negedge clk);

    // Reset values from the spec
    step("reset", 1, 0, 3'd0, 32'h0, 0, 0);
    check("rst.q8", {24'b0, ifc8.q}, 32'h00);
    check("rst.zero8", {31'b0, ifc8.zero}, 32'h1);
    check("rst.q1", {31'b0, ifc1.q}, 32'h1);
    check("rst.q16", {16'b0, ifc16.q}, 32'hFFFF);
    check("rst.zero16", {31'b0, ifc16.zero}, 32'h0);

    // Width-1: SHL loads sin_r, ROTL holds
    step("w1_shl", 0, 1, 3'd2, 32'h0, 0, 0);
    check("w1.shl", {31'b0, ifc1.q}, 32'h0);
    step("w1_load", 0, 1, 3'd1, 32'h1, 0, 0);
    step("w1_rotl", 0, 1, 3'd4, 32'h0, 0, 0);
    check("w1.rotl", {31'b0, ifc1.q}, 32'h1);

    // Width-16 clear
    step("w16_load", 0, 1, 3'd1, 32'h1234, 0, 0);
    step("w16_clr", 0, 1, 3'd6, 32'h0, 0, 0);
    check("w16.clear", {16'b0, ifc16.q}, 32'hFFFF);
    check("w16.clear_zero", {31'b0, ifc16.zero}, 32'h0);

    // Load and enable gating
    step("load_a5", 0, 1, 3'd1, 32'hA5A5, 0, 0);
    check("load.q", {24'b0, ifc8.q}, 32'hA5);
    check("load.sout_l", {31'b0, ifc8.sout_l}, 32'h1);
    check("load.sout_r", {31'b0, ifc8.sout_r}, 32'h1);
    for (int i = 0; i < 3; i++) step("gated", 0, 0, 3'd2, 32'h0, 1, 1);
    check("gate.q", {24'b0, ifc8.q}, 32'hA5);
    step("shl_en", 0, 1, 3'd2, 32'h0, 0, 0);
    check("shl.q", {24'b0, ifc8.q}, 32'h4A);

    // Shifts and rotates from 81
    step("ld81", 0, 1, 3'd1, 32'h8181, 0, 0);
    step("shr", 0, 1, 3'd3, 32'h0, 0, 1);
    check("shr.q", {24'b0, ifc8.q}, 32'hC0);
    step("ld81", 0, 1, 3'd1, 32'h8181, 0, 0);
    step("shl", 0, 1, 3'd2, 32'h0, 1, 0);
    check("shl1.q", {24'b0, ifc8.q}, 32'h03);
    step("ld81", 0, 1, 3'd1, 32'h8181, 0, 0);
    step("rotl", 0, 1, 3'd4, 32'h0, 0, 0);
    check("rotl.q", {24'b0, ifc8.q}, 32'h03);
    step("ld81", 0, 1, 3'd1, 32'h8181, 0, 0);
    step("rotr", 0, 1, 3'd5, 32'h0, 0, 0);
    check("rotr.q", {24'b0, ifc8.q}, 32'hC0);

    // Eight right shifts flush to zero; eight rotates restore
    step("ld_rand", 0, 1, 3'd1, $urandom, 0, 0);
    for (int i = 0; i < 8; i++) step("flush", 0, 1, 3'd3, 32'h0, 1, 0);
    check("flush.q", {24'b0, ifc8.q}, 32'h00);
    check("flush.zero", {31'b0, ifc8.zero}, 32'h1);
    step("ld5a", 0, 1, 3'd1, 32'h5A5A, 0, 0);
    for (int i = 0; i < 8; i++) step("rot8", 0, 1, 3'd4, 32'h0, 0, 0);
    check("rot8.q", {24'b0, ifc8.q}, 32'h5A);

    // Reset aborts a rotate sequence; reserved mode holds
    step("ld3c", 0, 1, 3'd1, 32'h3C3C, 0, 0);
    step("seq_rotl1", 0, 1, 3'd4, 32'h0, 0, 0);
    step("seq_rotl2", 0, 1, 3'd4, 32'h0, 0, 0);
    step("seq_rst", 1, 1, 3'd4, 32'h0, 0, 0);
    check("midrst.q", {24'b0, ifc8.q}, 32'h00);
    step("rsvd", 0, 1, 3'd7, 32'hFFFF, 1, 1);
    check("rsvd.q", {24'b0, ifc8.q}, 32'h00);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
